// File: rtl/ahb3lite_irq_gen.sv
// AHB3-Lite slave driving IRQ_CNT interrupt lines from software level bits and
// stretched edge pulses, each gated by a per-line mask.
module ahb3lite_irq_gen #(
   parameter int unsigned IRQ_CNT = 240,
   parameter int unsigned PULSE_W = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               HSEL,
   input  logic               HWRITE,
   input  logic               HREADY,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic [2:0]         HSIZE,
   input  logic [2:0]         HBURST,
   input  logic [3:0]         HPROT,
   input  logic [31:0]        HWDATA,
   output logic [31:0]        HRDATA,
   output logic               HRESP,
   output logic               HREADYOUT,
   output logic [IRQ_CNT-1:0] IRQ
);

   localparam int unsigned NWORDS = (IRQ_CNT + 31) / 32;
   localparam int unsigned NBITS  = NWORDS * 32;

   typedef enum logic [2:0] {RG_LEVEL, RG_EDGE, RG_MASK, RG_STATUS, RG_PLEN, RG_NONE} region_t;
   typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

   // Bits of word w that map onto real IRQ lines
   function automatic logic [31:0] vmask(input int unsigned w);
      logic [31:0] m;
      for (int unsigned b = 0; b < 32; b++) m[b] = ((w * 32 + b) < IRQ_CNT);
      return m;
   endfunction

   logic [31:0]        level_r [NWORDS];
   logic [31:0]        mask_r  [NWORDS];
   logic [31:0]        pulse_r [NWORDS];
   logic [PULSE_W-1:0] cnt_r   [NWORDS];
   logic [PULSE_W-1:0] plen_r;
   logic [PULSE_W-1:0] plen_eff;

   region_t     ap_region, dp_region;
   logic        ap_accept, ap_legal;
   logic        dp_act, dp_write, wr_en;
   logic [4:0]  dp_idx;
   state_t      state, state_nxt;
   logic [NBITS-1:0] irq_all;
   logic [31:0] rdata;
   logic        unused;

   assign unused = ^{HBURST, HPROT, HADDR[31:12], irq_all};

   // Address-phase decode
   always_comb begin
      ap_region = RG_NONE;
      if (HADDR[11:0] == 12'h3F0) begin
         ap_region = RG_PLEN;
      end else if (HADDR[11:10] == 2'b00 && !HADDR[7] && HADDR[1:0] == 2'b00 &&
                   32'(HADDR[6:2]) < NWORDS) begin
         case (HADDR[9:8])
            2'd0:    ap_region = RG_LEVEL;
            2'd1:    ap_region = RG_EDGE;
            2'd2:    ap_region = RG_MASK;
            default: ap_region = RG_STATUS;
         endcase
      end
   end

   assign ap_accept = HSEL & HREADY & HTRANS[1];
   assign ap_legal  = (HSIZE == 3'b010) && (ap_region != RG_NONE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         dp_act    <= 1'b0;
         dp_write  <= 1'b0;
         dp_region <= RG_NONE;
         dp_idx    <= '0;
      end else if (HREADY) begin
         dp_act    <= ap_accept & ap_legal;
         dp_write  <= HWRITE;
         dp_region <= ap_region;
         dp_idx    <= HADDR[6:2];
      end
   end

   assign wr_en = dp_act & dp_write;

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_OKAY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_OKAY;
      case (state)
         ST_ERR1: state_nxt = ST_ERR2;
         default: if (ap_accept && !ap_legal) state_nxt = ST_ERR1;
      endcase
   end

   always_comb begin
      HREADYOUT = (state != ST_ERR1);
      HRESP     = (state != ST_OKAY);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         plen_r <= PULSE_W'(1);
         for (int unsigned w = 0; w < NWORDS; w++) begin
            level_r[w] <= '0;
            mask_r[w]  <= vmask(w);
         end
      end else if (wr_en) begin
         if (dp_region == RG_PLEN) plen_r <= HWDATA[PULSE_W-1:0];
         for (int unsigned w = 0; w < NWORDS; w++) begin
            if (dp_idx == 5'(w) && dp_region == RG_LEVEL) level_r[w] <= HWDATA & vmask(w);
            if (dp_idx == 5'(w) && dp_region == RG_MASK)  mask_r[w]  <= HWDATA & vmask(w);
         end
      end
   end

   assign plen_eff = (plen_r == '0) ? PULSE_W'(1) : plen_r;

   // A nonzero EDGE write ORs in new bits and restarts the whole group's counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned w = 0; w < NWORDS; w++) begin
            pulse_r[w] <= '0;
            cnt_r[w]   <= '0;
         end
      end else begin
         for (int unsigned w = 0; w < NWORDS; w++) begin
            if (wr_en && dp_region == RG_EDGE && dp_idx == 5'(w) &&
                (HWDATA & vmask(w)) != 32'h0) begin
               pulse_r[w] <= pulse_r[w] | (HWDATA & vmask(w));
               cnt_r[w]   <= plen_eff;
            end else if (cnt_r[w] != '0) begin
               cnt_r[w] <= cnt_r[w] - PULSE_W'(1);
               if (cnt_r[w] == PULSE_W'(1)) pulse_r[w] <= '0;
            end
         end
      end
   end

   always_comb begin
      irq_all = '0;
      for (int unsigned w = 0; w < NWORDS; w++)
         irq_all[w*32 +: 32] = (level_r[w] | pulse_r[w]) & mask_r[w];
   end

   assign IRQ = irq_all[IRQ_CNT-1:0];

   always_comb begin
      rdata = '0;
      if (dp_act && !dp_write) begin
         for (int unsigned w = 0; w < NWORDS; w++) begin
            if (dp_idx == 5'(w)) begin
               case (dp_region)
                  RG_LEVEL:  rdata = level_r[w];
                  RG_MASK:   rdata = mask_r[w];
                  RG_STATUS: rdata = irq_all[w*32 +: 32];
                  default:   ;
               endcase
            end
         end
         if (dp_region == RG_PLEN) rdata = 32'(plen_r);
      end
   end

   assign HRDATA = rdata;

endmodule

// File: tb/tb_ahb3lite_irq_gen.sv
// Directed bench for ahb3lite_irq_gen: register access, pulse timing, masking,
// error responses and reset.
module tb_ahb3lite_irq_gen;

   logic         CLK, RESET, HSEL, HWRITE, HREADY;
   logic [31:0]  HADDR, HWDATA, HRDATA;
   logic [1:0]   HTRANS;
   logic [2:0]   HSIZE, HBURST;
   logic [3:0]   HPROT;
   logic         HRESP, HREADYOUT;
   logic [239:0] IRQ;

   int n_cmp = 0;
   int n_bad = 0;

   ahb3lite_irq_gen #(.IRQ_CNT(240), .PULSE_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP), .HREADYOUT(HREADYOUT), .IRQ(IRQ)
   );

   assign HREADY = HREADYOUT;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // One transfer: address phase, then data phase until HREADYOUT (bounded)
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] size, output logic [31:0] rdata,
                       output logic resp, output int waits, output logic first_resp);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = size;
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      first_resp = HRESP;
      waits = 0;
      while (HREADYOUT !== 1'b1 && waits < 4) begin
         tick();
         waits++;
      end
      rdata = HRDATA;
      resp  = HRESP;
      tick();
   endtask

   task automatic wr32(input string tag, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r; logic rs, fr; int wt;
      xfer(1'b1, a, d, 3'b010, r, rs, wt, fr);
      check({tag, "_okay"}, 32'({rs, 8'(wt)}), 32'h0);
   endtask

   task automatic rd32(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r; logic rs, fr; int wt;
      xfer(1'b0, a, 32'h0, 3'b010, r, rs, wt, fr);
      check({tag, "_okay"}, 32'({rs, 8'(wt)}), 32'h0);
      check(tag, r, exp);
   endtask

   task automatic err(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] size);
      logic [31:0] r; logic rs, fr; int wt;
      xfer(wr, a, 32'h0000_00AA, size, r, rs, wt, fr);
      // first data cycle HRESP=1 with one wait state, final cycle HRESP=1
      check(tag, 32'({fr, rs, 8'(wt)}), 32'h0000_0301);
   endtask

   initial begin
      RESET = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HTRANS = 2'b00;
      HSIZE = 3'b010; HBURST = '0; HPROT = '0; HWDATA = '0;
      repeat (3) tick();
      check("rst_bus", 32'({HREADYOUT, HRESP}), 32'h2);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_irq", 32'(IRQ === '0), 32'h1);
      RESET = 1'b0;
      tick();
      rd32("rst_mask0", 32'h200, 32'hFFFF_FFFF);
      rd32("rst_plen", 32'h3F0, 32'h0000_0001);
      rd32("rst_level0", 32'h000, 32'h0000_0000);

      // Level bits
      wr32("lvl1_wr", 32'h004, 32'h0000_0005);
      check("lvl1_irq_t1", 32'(IRQ[34:32]), 32'h5);
      tick(); tick();
      check("lvl1_irq_hold", 32'(IRQ[34:32]), 32'h5);
      rd32("lvl1_rd", 32'h004, 32'h0000_0005);
      wr32("lvl7_wr", 32'h01C, 32'hFFFF_FFFF);
      rd32("lvl7_rd", 32'h01C, 32'h0000_FFFF);
      rd32("edge_rd0", 32'h100, 32'h0);

      // Back-to-back write then read of the same register
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h008; HSIZE = 3'b010;
      tick();
      HWDATA = 32'h0000_1234; HWRITE = 1'b0; HADDR = 32'h008;
      tick();
      HSEL = 1'b0; HTRANS = 2'b00;
      check("b2b_rd", HRDATA, 32'h0000_1234);
      check("b2b_resp", 32'({HREADYOUT, HRESP}), 32'h2);
      tick();

      // Pulse length: upper bits ignored, then single 4-cycle pulse
      wr32("plen_wr", 32'h3F0, 32'hABCD_0104);
      rd32("plen_rd", 32'h3F0, 32'h0000_0004);
      wr32("edge0_wr", 32'h100, 32'h0000_0001);
      check("pulse_t1", 32'(IRQ[1:0]), 32'h1);
      tick(); check("pulse_t2", 32'(IRQ[1:0]), 32'h1);
      tick(); check("pulse_t3", 32'(IRQ[1:0]), 32'h1);
      tick(); check("pulse_t4", 32'(IRQ[1:0]), 32'h1);
      tick(); check("pulse_t5_off", 32'(IRQ[1:0]), 32'h0);
      wr32("edge0_nul", 32'h100, 32'h0);
      check("edge_zero_noop", 32'(IRQ[1:0]), 32'h0);

      // Extension: second EDGE write two cycles after the first (T -> T+2)
      wr32("ext_a", 32'h100, 32'h0000_0001);
      wr32("ext_b", 32'h100, 32'h0000_0002);
      check("ext_t3", 32'(IRQ[1:0]), 32'h3);
      tick(); check("ext_t4", 32'(IRQ[1:0]), 32'h3);
      tick(); check("ext_t5", 32'(IRQ[1:0]), 32'h3);
      tick(); check("ext_t6", 32'(IRQ[1:0]), 32'h3);
      tick(); check("ext_t7_off", 32'(IRQ[1:0]), 32'h0);

      // Masking
      wr32("mask0_clr", 32'h200, 32'h0);
      wr32("lvl0_set", 32'h000, 32'h0000_0001);
      check("masked_irq", 32'(IRQ[0]), 32'h0);
      rd32("masked_status", 32'h300, 32'h0);
      wr32("mask0_set", 32'h200, 32'hFFFF_FFFF);
      check("unmasked_irq", 32'(IRQ[0]), 32'h1);
      wr32("status_wr", 32'h300, 32'h0);
      rd32("status_rd", 32'h300, 32'h0000_0001);

      // Legality
      rd32("rd_i7", 32'h01C, 32'h0000_FFFF);
      err("err_i8", 1'b0, 32'h020, 3'b010);
      err("err_byte", 1'b1, 32'h000, 3'b000);
      rd32("lvl0_kept", 32'h000, 32'h0000_0001);
      err("err_unmapped", 1'b1, 32'h3F4, 3'b010);
      rd32("plen_kept", 32'h3F0, 32'h0000_0004);

      // PULSE_LEN=0 behaves as 1
      wr32("plen0_wr", 32'h3F0, 32'h0);
      wr32("edge4_wr", 32'h110, 32'h0000_0001);
      check("plen0_t1", 32'(IRQ[128]), 32'h1);
      tick(); check("plen0_t2_off", 32'(IRQ[128]), 32'h0);

      // Reset mid-pulse
      wr32("plen200_wr", 32'h3F0, 32'h0000_00C8);
      wr32("edge3_wr", 32'h10C, 32'h0000_0010);
      check("long_pulse_on", 32'(IRQ[100]), 32'h1);
      repeat (5) tick();
      check("long_pulse_mid", 32'(IRQ[100]), 32'h1);
      RESET = 1'b1;
      tick();
      check("rst2_irq", 32'(IRQ === '0), 32'h1);
      RESET = 1'b0;
      tick();
      check("rst2_irq_hold", 32'(IRQ === '0), 32'h1);
      rd32("rst2_plen", 32'h3F0, 32'h0000_0001);
      rd32("rst2_level1", 32'h004, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
